// File: rtl/full_adder4.sv
// Registered N-bit adder built from 4-bit carry-lookahead groups, one result per cycle.
// Optional macro FULL_ADDER4_OVF_EN adds a registered two's-complement overflow flag (ovf).
module full_adder4 #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] sum,
  output logic         cout,
`ifdef FULL_ADDER4_OVF_EN
  output logic         ovf,
`endif
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b
);

  localparam int NG = (N + 3) / 4;

  logic [N-1:0] p, g;
  logic [N:0]   c;
  logic         cg, cg_nxt, t, pr;
  logic [N-1:0] sum_d, sum_q;
  logic         cout_d, cout_q;

  // Each group resolves its internal carries directly from the group carry-in;
  // only the group carry ripples into the next group. The last group may be partial.
  always_comb begin
    p      = a ^ b;
    g      = a & b;
    c      = '0;
    c[0]   = cin;
    cg     = cin;
    cg_nxt = cin;
    t      = 1'b0;
    pr     = 1'b0;
    for (int gi = 0; gi < NG; gi++) begin
      cg_nxt = cg;
      for (int j = 0; j < 4; j++) begin
        if (gi * 4 + j < N) begin
          t = cg;
          for (int m = 0; m <= j; m++) t = t & p[gi*4+m];
          for (int k = 0; k <= j; k++) begin
            pr = g[gi*4+k];
            for (int m = k + 1; m <= j; m++) pr = pr & p[gi*4+m];
            t = t | pr;
          end
          c[gi*4+j+1] = t;
          cg_nxt      = t;
        end
      end
      cg = cg_nxt;
    end
    sum_d  = p ^ c[N-1:0];
    cout_d = c[N];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef FULL_ADDER4_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: like-signed operands producing a result of the other sign.
  assign ovf_d = (a[N-1] == b[N-1]) && (sum_d[N-1] != a[N-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder4.sv
// Bench for full_adder4: directed vector table, hand sequences and random sweep at N=1,4,5,8.
module tb_full_adder4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] a4, b4, s4;
  logic       ci4, co4;
  logic       a1, b1, s1, ci1, co1;
  logic [4:0] a5, b5, s5;
  logic       ci5, co5;
  logic [7:0] a8, b8, s8;
  logic       ci8, co8;
`ifdef FULL_ADDER4_OVF_EN
  logic ov4, ov1, ov5, ov8;
`endif

  full_adder4 #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .sum(s4), .cout(co4),
`ifdef FULL_ADDER4_OVF_EN
    .ovf(ov4),
`endif
    .cin(ci4), .a(a4), .b(b4));
  full_adder4 #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .sum(s1), .cout(co1),
`ifdef FULL_ADDER4_OVF_EN
    .ovf(ov1),
`endif
    .cin(ci1), .a(a1), .b(b1));
  full_adder4 #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .sum(s5), .cout(co5),
`ifdef FULL_ADDER4_OVF_EN
    .ovf(ov5),
`endif
    .cin(ci5), .a(a5), .b(b5));
  full_adder4 #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .sum(s8), .cout(co8),
`ifdef FULL_ADDER4_OVF_EN
    .ovf(ov8),
`endif
    .cin(ci8), .a(a8), .b(b8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: full-precision unsigned sum, zero while in reset.
  function automatic longint ref_sum(input bit rst_ok, input longint x, input longint y, input longint ci);
    return rst_ok ? (x + y + ci) : 0;
  endfunction

  function automatic longint ref_ovf(input bit rst_ok, input int n, input longint x, input longint y, input longint ci);
    longint s, sa, sb, ss;
    if (!rst_ok) return 0;
    s  = x + y + ci;
    sa = (x >> (n - 1)) & 1;
    sb = (y >> (n - 1)) & 1;
    ss = (s >> (n - 1)) & 1;
    return (sa == sb && ss != sa) ? 1 : 0;
  endfunction

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       rst_n;
    logic [3:0] s;
    logic       co;
  } vec_t;

  vec_t tbl[$];
  longint e4, e1, e5, e8;
  bit     r;

  initial begin
    tbl.push_back('{4'd1,  4'd1,  1'b0, 1'b1, 4'd2,  1'b0});
    tbl.push_back('{4'd7,  4'd8,  1'b0, 1'b1, 4'd15, 1'b0});
    tbl.push_back('{4'd6,  4'd9,  1'b0, 1'b1, 4'd15, 1'b0});
    tbl.push_back('{4'd3,  4'd7,  1'b0, 1'b1, 4'd10, 1'b0});
    tbl.push_back('{4'd4,  4'd4,  1'b1, 1'b1, 4'd9,  1'b0});
    tbl.push_back('{4'd8,  4'd5,  1'b1, 1'b1, 4'd14, 1'b0});
    tbl.push_back('{4'd2,  4'd3,  1'b1, 1'b1, 4'd6,  1'b0});
    tbl.push_back('{4'd5,  4'd6,  1'b1, 1'b1, 4'd12, 1'b0});
    tbl.push_back('{4'd15, 4'd1,  1'b0, 1'b1, 4'd0,  1'b1});
    tbl.push_back('{4'd15, 4'd15, 1'b1, 1'b1, 4'd15, 1'b1});
    tbl.push_back('{4'd8,  4'd8,  1'b1, 1'b1, 4'd1,  1'b1});
    tbl.push_back('{4'd8,  4'd8,  1'b1, 1'b0, 4'd0,  1'b0});
    tbl.push_back('{4'd8,  4'd8,  1'b1, 1'b1, 4'd1,  1'b1});

    // Reset with undriven operands
    rst_n = 1'b0;
    a4 = 'x; b4 = 'x; ci4 = 'x;
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    a5 = '0; b5 = '0; ci5 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0;
    @(posedge clk); #1;
    chk("reset1_sum", s4, 0);
    chk("reset1_cout", co4, 0);
    @(posedge clk); #1;
    chk("reset2_sum", s4, 0);
    chk("reset2_cout", co4, 0);

    foreach (tbl[i]) begin
      a4 = tbl[i].a; b4 = tbl[i].b; ci4 = tbl[i].cin; rst_n = tbl[i].rst_n;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_sum", i), s4, tbl[i].s);
      chk($sformatf("vec%0d_cout", i), co4, tbl[i].co);
    end

    // Carry-in alone changes the result on the next edge
    rst_n = 1'b1; a4 = 4'd5; b4 = 4'd5; ci4 = 1'b0;
    @(posedge clk); #1;
    chk("cin0_sum", s4, 10);
    ci4 = 1'b1;
    @(posedge clk); #1;
    chk("cin1_sum", s4, 11);

    // Falling rst_n between edges must not disturb the outputs
    a4 = 4'd3; b4 = 4'd4; ci4 = 1'b0;
    @(posedge clk); #1;
    chk("pre_sync_sum", s4, 7);
    rst_n = 1'b0;
    #2;
    chk("sync_hold_sum", s4, 7);
    @(posedge clk); #1;
    chk("sync_clear_sum", s4, 0);
    rst_n = 1'b1;

`ifdef FULL_ADDER4_OVF_EN
    a4 = 4'd7; b4 = 4'd1; ci4 = 1'b0;
    @(posedge clk); #1;
    chk("ovf_7p1", ov4, 1);
    a4 = 4'd3; b4 = 4'd1;
    @(posedge clk); #1;
    chk("ovf_3p1", ov4, 0);
`endif

    // Random sweep across widths, with occasional resets
    for (int n = 0; n < 1000; n++) begin
      r = ($urandom_range(0, 39) != 0);
      rst_n = r;
      a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      a5 = 5'($urandom); b5 = 5'($urandom); ci5 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      e4 = ref_sum(r, a4, b4, ci4);
      e1 = ref_sum(r, a1, b1, ci1);
      e5 = ref_sum(r, a5, b5, ci5);
      e8 = ref_sum(r, a8, b8, ci8);
`ifdef FULL_ADDER4_OVF_EN
      begin
        longint o4, o1, o5, o8;
        o4 = ref_ovf(r, 4, a4, b4, ci4);
        o1 = ref_ovf(r, 1, a1, b1, ci1);
        o5 = ref_ovf(r, 5, a5, b5, ci5);
        o8 = ref_ovf(r, 8, a8, b8, ci8);
        @(posedge clk); #1;
        chk("rnd_ovf4", ov4, o4);
        chk("rnd_ovf1", ov1, o1);
        chk("rnd_ovf5", ov5, o5);
        chk("rnd_ovf8", ov8, o8);
      end
`else
      @(posedge clk); #1;
`endif
      chk("rnd_n4", {co4, s4}, e4);
      chk("rnd_n1", {co1, s1}, e1);
      chk("rnd_n5", {co5, s5}, e5);
      chk("rnd_n8", {co8, s8}, e8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
